// File: rtl/pipe_data_packer_if.sv
// Narrow-in / wide-out valid-ready bundle for the data packer.
// The master drives the narrow beats and the downstream ready; the slave is the packer.
interface pipe_data_packer_if #(
  parameter int IWIDTH = 8,
  parameter int RATIO  = 4
);
  logic                      i_valid;
  logic [IWIDTH-1:0]         i_data;
  logic                      i_last;
  logic                      o_ready;
  logic                      o_valid;
  logic [IWIDTH*RATIO-1:0]   o_data;
  logic [RATIO-1:0]          o_keep;
  logic                      o_last;
  logic                      i_ready;

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_keep, o_last
  );

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_keep, o_last
  );
endinterface

// File: rtl/pipe_data_packer.sv
// Valid-ready width upsizer: packs RATIO narrow beats (little-endian lanes) into one
// registered wide word; i_last closes a word early and o_keep marks the filled lanes.
module pipe_data_packer #(
  parameter int IWIDTH = 8,
  parameter int RATIO  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  pipe_data_packer_if.slave   bus
);
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OW = IWIDTH * RATIO;

  generate
    if (RATIO < 2) begin : g_bad_ratio
      $error("pipe_data_packer: RATIO must be 2 or more");
    end
  endgenerate

  logic                init_done_reg;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [OW-1:0]       acc_reg, acc_next;
  logic [RATIO-1:0]    acc_keep_reg, acc_keep_next;
  logic [OW-1:0]       out_data_reg, out_data_next;
  logic [RATIO-1:0]    out_keep_reg, out_keep_next;
  logic                out_last_reg, out_last_next;
  logic                out_valid_reg, out_valid_next;

  logic [OW-1:0]       merged_data;
  logic [RATIO-1:0]    merged_keep;
  logic                accept;
  logic                take;
  logic                complete;

  // Accumulator with the current beat dropped into the lane selected by cnt.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      logic lane_sel;
      assign lane_sel = (cnt_reg == CW'(gi));
      assign merged_data[gi*IWIDTH +: IWIDTH] = lane_sel ? bus.i_data
                                                         : acc_reg[gi*IWIDTH +: IWIDTH];
      assign merged_keep[gi] = lane_sel | acc_keep_reg[gi];
    end
  endgenerate

  assign bus.o_ready = init_done_reg && (!out_valid_reg || bus.i_ready);
  assign accept      = bus.i_valid && bus.o_ready;
  assign take        = out_valid_reg && bus.i_ready;
  assign complete    = accept && ((cnt_reg == CW'(RATIO - 1)) || bus.i_last);

  always_comb begin
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    acc_keep_next  = acc_keep_reg;
    out_data_next  = out_data_reg;
    out_keep_next  = out_keep_reg;
    out_last_next  = out_last_reg;
    out_valid_next = out_valid_reg;

    if (take) begin
      out_valid_next = 1'b0;
    end

    // A completion beat overrides the take above, giving a back-to-back reload.
    if (complete) begin
      out_data_next  = merged_data;
      out_keep_next  = merged_keep;
      out_last_next  = bus.i_last;
      out_valid_next = 1'b1;
      acc_next       = '0;
      acc_keep_next  = '0;
      cnt_next       = '0;
    end else if (accept) begin
      acc_next       = merged_data;
      acc_keep_next  = merged_keep;
      cnt_next       = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_done_reg <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      acc_keep_reg  <= '0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      init_done_reg <= 1'b1;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      acc_keep_reg  <= acc_keep_next;
      out_data_reg  <= out_data_next;
      out_keep_reg  <= out_keep_next;
      out_last_reg  <= out_last_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign bus.o_valid = out_valid_reg;
  assign bus.o_data  = out_data_reg;
  assign bus.o_keep  = out_keep_reg;
  assign bus.o_last  = out_last_reg;
endmodule
